// File: rtl/charge_pkg.sv
// Shared types and constants for the per-counter charging accumulator.
package charge_pkg;

    localparam int unsigned CNT_AW_DEF = 4;
    localparam int unsigned BYTE_W     = 48;
    localparam int unsigned PKT_W      = 32;
    localparam int unsigned TS_W       = 24;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned CID_W      = 14;
    localparam int unsigned PID_W      = 96;
    localparam int unsigned DROP_W     = 32;

    localparam logic [BYTE_W-1:0] QUOTA_DEF = 48'd102400;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] ul_bytes;
        logic [BYTE_W-1:0] dl_bytes;
        logic [PKT_W-1:0]  pkts;
        logic [TS_W-1:0]   ts;
    } entry_t;

    // Byte-counter add that sticks at all-ones instead of wrapping.
    function automatic logic [BYTE_W-1:0] sat_add(input logic [BYTE_W-1:0] a,
                                                  input logic [BYTE_W-1:0] b);
        logic [BYTE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[BYTE_W] ? {BYTE_W{1'b1}} : s[BYTE_W-1:0];
    endfunction

    // Packet-counter increment that sticks at all-ones.
    function automatic logic [PKT_W-1:0] sat_inc(input logic [PKT_W-1:0] a);
        return (&a) ? a : a + PKT_W'(1);
    endfunction

endpackage

// File: rtl/charge_accum_if.sv
// Packet stream from the packet generator into the charging accumulator.
interface charge_accum_if import charge_pkg::*; ();

    logic             in_vld;
    logic             in_rdy;
    logic [PID_W-1:0] in_pkt_id;
    logic [LEN_W-1:0] in_pkt_len;
    logic [CID_W-1:0] in_cnt_id;
    logic             in_cnt_en;
    logic             in_ul;

    modport master (
        output in_vld, in_pkt_id, in_pkt_len, in_cnt_id, in_cnt_en, in_ul,
        input  in_rdy
    );

    modport slave (
        input  in_vld, in_pkt_id, in_pkt_len, in_cnt_id, in_cnt_en, in_ul,
        output in_rdy
    );

endinterface

// File: rtl/charge_entry_upd.sv
// Combinational next-entry computation: saturating byte/packet update and
// detection of the (UL+DL) quota crossing.
module charge_entry_upd import charge_pkg::*; #(
    parameter logic [BYTE_W-1:0] QUOTA = QUOTA_DEF
) (
    input  entry_t           cur,
    input  logic [LEN_W-1:0] len,
    input  logic             ul,
    input  logic [TS_W-1:0]  ts,
    output entry_t           nxt_c,
    output logic             cross_c
);

    localparam logic [BYTE_W:0] QUOTA_X = {1'b0, QUOTA};

    logic [BYTE_W-1:0] len_x;
    logic [BYTE_W:0]   old_sum;
    logic [BYTE_W:0]   new_sum;

    assign len_x = BYTE_W'(len);

    // Apply one packet to the entry and compare totals before and after.
    always_comb begin
        nxt_c = cur;
        if (ul) begin
            nxt_c.ul_bytes = sat_add(cur.ul_bytes, len_x);
        end else begin
            nxt_c.dl_bytes = sat_add(cur.dl_bytes, len_x);
        end
        nxt_c.pkts = sat_inc(cur.pkts);
        nxt_c.ts   = ts;
        old_sum    = {1'b0, cur.ul_bytes} + {1'b0, cur.dl_bytes};
        new_sum    = {1'b0, nxt_c.ul_bytes} + {1'b0, nxt_c.dl_bytes};
        cross_c    = (old_sum < QUOTA_X) && (new_sum >= QUOTA_X);
    end

endmodule

// File: rtl/charge_accum.sv
// Per-counter charging accumulator: two-stage update of a UL/DL byte, packet
// and timestamp table, single-cycle readout with write bypass, quota event.
// Optional build macro CHARGE_CLR_ON_READ_EN makes readout clear the entry.
module charge_accum import charge_pkg::*; #(
    parameter int unsigned       CNT_AW = CNT_AW_DEF,
    parameter logic [BYTE_W-1:0] QUOTA  = QUOTA_DEF
) (
    input  logic               asclk,
    input  logic               aresetn,
    charge_accum_if.slave      pkt,
    input  logic [TS_W-1:0]    timer,
    input  logic               rd_req,
    input  logic [CNT_AW-1:0]  rd_id,
    output logic               rd_vld,
    output logic [BYTE_W-1:0]  rd_ul_bytes,
    output logic [BYTE_W-1:0]  rd_dl_bytes,
    output logic [PKT_W-1:0]   rd_pkts,
    output logic [TS_W-1:0]    rd_ts,
    output logic               quota_hit,
    output logic [CNT_AW-1:0]  quota_id,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic [PID_W-1:0]   err_pkt_id
);

    localparam int unsigned DEPTH = 1 << CNT_AW;

    state_e            state_q, state_d;
    logic [CNT_AW-1:0] init_ptr_q;
    logic              in_rdy_q;

    logic              s1_vld;
    logic [LEN_W-1:0]  s1_len;
    logic [CNT_AW-1:0] s1_idx;
    logic              s1_ul;
    logic [TS_W-1:0]   s1_ts;
    logic              s1_en;
    logic              s1_oor;
    logic [PID_W-1:0]  s1_pid;

    logic              accept_c;
    logic              wr_c;
    logic              rd_go_c;
    logic              cross_c;
    entry_t            base_c;
    entry_t            upd_c;
    entry_t            rd_eff_c;
    logic              clr_pend;
    logic [CNT_AW-1:0] clr_idx;

    entry_t            tbl [DEPTH];

    assign accept_c   = pkt.in_vld && in_rdy_q;
    assign wr_c       = s1_vld && s1_en && !s1_oor;
    assign rd_go_c    = rd_req && (state_q == ST_RUN);
    assign pkt.in_rdy = in_rdy_q;

    // State register, init sweep pointer and registered ready.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            in_rdy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= (state_d == ST_RUN);
            if (state_q == ST_INIT) begin
                init_ptr_q <= init_ptr_q + CNT_AW'(1);
            end
        end
    end

    // Leave INIT once the last table entry has been cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_ptr_q == CNT_AW'(DEPTH - 1)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Stage 1: capture the accepted packet and its out-of-range flag.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_vld <= 1'b0;
            s1_len <= '0;
            s1_idx <= '0;
            s1_ul  <= 1'b0;
            s1_ts  <= '0;
            s1_en  <= 1'b0;
            s1_oor <= 1'b0;
            s1_pid <= '0;
        end else begin
            s1_vld <= accept_c;
            if (accept_c) begin
                s1_len <= pkt.in_pkt_len;
                s1_idx <= pkt.in_cnt_id[CNT_AW-1:0];
                s1_ul  <= pkt.in_ul;
                s1_ts  <= timer;
                s1_en  <= pkt.in_cnt_en;
                s1_oor <= |pkt.in_cnt_id[CID_W-1:CNT_AW];
                s1_pid <= pkt.in_pkt_id;
            end
        end
    end

`ifdef CHARGE_CLR_ON_READ_EN
    // Remember which entry was read so it is cleared in the rd_vld cycle.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            clr_pend <= 1'b0;
            clr_idx  <= '0;
        end else begin
            clr_pend <= rd_go_c;
            clr_idx  <= rd_id;
        end
    end
`else
    assign clr_pend = 1'b0;
    assign clr_idx  = '0;
`endif

    // Entry seen by the update: a same-cycle clear leaves only this packet.
    always_comb begin
        base_c = tbl[s1_idx];
        if (clr_pend && (clr_idx == s1_idx)) base_c = '0;
    end

    charge_entry_upd #(.QUOTA(QUOTA)) u_upd (
        .cur     (base_c),
        .len     (s1_len),
        .ul      (s1_ul),
        .ts      (s1_ts),
        .nxt_c   (upd_c),
        .cross_c (cross_c)
    );

    // Readout value after this cycle's clear and stage-2 write.
    always_comb begin
        rd_eff_c = tbl[rd_id];
        if (clr_pend && (clr_idx == rd_id)) rd_eff_c = '0;
        if (wr_c && (s1_idx == rd_id))      rd_eff_c = upd_c;
    end

    // Table storage: sweep-clear in INIT, then read-clear and stage-2 write.
    always_ff @(posedge asclk) begin
        if (state_q == ST_INIT) begin
            tbl[init_ptr_q] <= '0;
        end else begin
            if (clr_pend) tbl[clr_idx] <= '0;
            if (wr_c)     tbl[s1_idx]  <= upd_c;
        end
    end

    // Registered readout, quota pulse and drop accounting.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_vld      <= 1'b0;
            rd_ul_bytes <= '0;
            rd_dl_bytes <= '0;
            rd_pkts     <= '0;
            rd_ts       <= '0;
            quota_hit   <= 1'b0;
            quota_id    <= '0;
            drop_cnt    <= '0;
            err_pkt_id  <= '0;
        end else begin
            rd_vld    <= rd_go_c;
            quota_hit <= wr_c && cross_c;
            if (rd_go_c) begin
                rd_ul_bytes <= rd_eff_c.ul_bytes;
                rd_dl_bytes <= rd_eff_c.dl_bytes;
                rd_pkts     <= rd_eff_c.pkts;
                rd_ts       <= rd_eff_c.ts;
            end
            if (wr_c && cross_c) quota_id <= s1_idx;
            if (s1_vld && (!s1_en || s1_oor)) drop_cnt <= drop_cnt + DROP_W'(1);
            if (s1_vld && s1_oor) err_pkt_id <= s1_pid;
        end
    end

endmodule

// File: doc/charge_accum.md
Name: charge_accum

Overview:
- Per-counter charging accumulator directly downstream of the packet generator.
- Consumes the packet stream (valid/ready, packet id, length, counter id, count-enable, UL/DL flag, timestamp).
- Accumulates UL bytes, DL bytes, packet count and last-seen timestamp per counter id in a register table.
- Exposes a single-cycle readout port and a quota-crossing event.

Parameters:
- CNT_AW, 4, table index width; 2^CNT_AW entries
- BYTE_W, 48, width of each UL/DL byte counter
- PKT_W, 32, width of the per-entry packet counter
- QUOTA, 48'd102400, byte threshold on (UL+DL) for quota_hit

Ports:
- asclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- in_vld  in  1  packet valid
- in_rdy  out  1  ready; high only in RUN state
- in_pkt_id  in  96  packet id; carried to err_pkt_id only
- in_pkt_len  in  16  packet length in bytes
- in_cnt_id  in  14  counter id
- in_cnt_en  in  1  1 = charge this packet
- in_ul  in  1  1 = uplink, 0 = downlink
- timer  in  24  free-running timestamp
- rd_req  in  1  readout request
- rd_id  in  CNT_AW  readout index
- rd_vld  out  1  readout data valid
- rd_ul_bytes  out  BYTE_W  entry UL byte count
- rd_dl_bytes  out  BYTE_W  entry DL byte count
- rd_pkts  out  PKT_W  entry packet count
- rd_ts  out  24  entry last-update timestamp
- quota_hit  out  1  one-cycle pulse on quota crossing
- quota_id  out  CNT_AW  entry that crossed the quota
- drop_cnt  out  32  packets accepted but not charged
- err_pkt_id  out  96  id of the last out-of-range packet

Behaviour:
- Reset (async) → state INIT, init pointer = 0. All outputs reset to 0, including in_rdy, rd_vld and quota_hit.
- INIT state:
  - Clears one table entry per cycle, in 2^CNT_AW cycles, then moves to RUN.
  - in_rdy stays 0 throughout INIT.
  - rd_req is ignored during INIT; rd_vld stays 0.
- RUN state: in_rdy = 1, held constantly. No backpressure; throughput is one packet per cycle.
- Accept: a transfer occurs when in_vld && in_rdy.
- Stage S1 (the cycle after accept): registers {len, idx = in_cnt_id[CNT_AW-1:0], ul, ts, en, oor}.
  - oor = |in_cnt_id[13:CNT_AW].
- Stage S2 (the cycle after S1), applied only if en && !oor:
  - ul=1: ul_bytes += len; ul=0: dl_bytes += len.
  - pkts += 1.
  - ts = captured timer value.
- Latency: the table entry is updated 2 cycles after accept.
- Back-to-back packets to the same idx accumulate correctly; no packet is lost or double-counted.
- Arithmetic: length is zero-extended to BYTE_W. Byte and packet counters saturate at all-ones and never wrap.
- Drop and error handling:
  - en=0: drop_cnt += 1.
  - oor=1: drop_cnt += 1 and err_pkt_id is loaded.
  - A packet with both conditions counts once.
  - drop_cnt wraps at 2^32.
- Quota:
  - Condition: old (ul+dl) < QUOTA and new (ul+dl) >= QUOTA.
  - Response: quota_hit = 1 for one cycle, together with the S2 write; quota_id = idx.
  - An entry already at or above QUOTA produces no further pulse.
- Readout:
  - rd_req in RUN → rd_vld = 1 next cycle, carrying the entry contents.
  - If the S2 write targets rd_id in the same cycle as rd_req, the readout returns the post-write value (bypass).
  - Back-to-back requests are allowed.
- Reset mid-operation: in-flight S1/S2 packets are discarded, the table is re-cleared, and in_rdy falls immediately.

Optional Feature:
- Macro: CHARGE_CLR_ON_READ_EN.
- Defined: a readout clears the entry in the cycle rd_vld is asserted.
  - If an S2 write hits the same entry in the request cycle, the returned data includes that packet. The entry is left at 0.
  - If an S2 write hits the entry in the clear cycle, the entry holds only that packet's contribution.
- Undefined: readout is non-destructive.

Decomposition:
- Package charge_pkg:
  - entry struct {ul_bytes, dl_bytes, pkts, ts}
  - INIT/RUN state encoding
  - saturating-add helper function
  - default QUOTA constant
- One sub-module, charge_entry_upd: combinational next-entry computation (saturating add, quota crossing detect), instanced at S2.

Test Plan:
- Reset released → in_rdy low for 16 cycles, then high; a readout of every entry returns all zeros.
- 3 DL packets of len 1024 to id 2 back-to-back → read id 2 gives dl=3072, ul=0, pkts=3, ts = timer value of the 3rd accept.
- 100 UL packets of 1024 to id 5 → quota_hit pulses exactly once, on the 100th packet (102400 bytes), with quota_id = 5.
- in_cnt_id=14'h0013 (oor) and a separate packet with in_cnt_en=0 → drop_cnt = 2, err_pkt_id = id of the oor packet, table unchanged.
- rd_req id 2 in the same cycle as the S2 write to id 2 → rd_vld data includes that packet. With CHARGE_CLR_ON_READ_EN, a second read returns zeros.
- Preload entry ul = 2^48-100, then send len 1024 → ul saturates at 48'hFFFF_FFFF_FFFF.
